// File: rtl/pc_fetch_ctrl.sv
// Registered PC / fetch-address controller with redirect parking while fetch is blocked.
// Build option PCFETCH_RVC_EN: 2-byte target alignment, misaligned pulse tied low.
module pc_fetch_ctrl #(
    parameter int          XLEN         = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic [1:0]      pc_src_in,
    input  logic            branch_taken_in,
    input  logic [XLEN-1:0] iaddr_in,
    input  logic [XLEN-1:0] epc_in,
    input  logic [XLEN-1:0] trap_address_in,
    input  logic            stall_in,
    input  logic            ahb_ready_in,
    output logic [XLEN-1:0] iaddr_out,
    output logic [XLEN-1:0] pc_plus_4_out,
    output logic            fetch_valid_out,
    output logic            redirect_pending_out,
    output logic            misaligned_instr_logic_out
);

    localparam logic [XLEN-1:0] RST_PC = XLEN'(RESET_VECTOR);

    typedef enum logic [1:0] {ST_RESET, ST_RUN, ST_HOLD} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] hold_addr_q, hold_addr_d;
    logic            hold_br_q, hold_br_d;
    logic            mis_q, mis_d;

    logic            br_req;
    logic            misaligned;
    logic            redirect;
    logic            adv;
    logic [XLEN-1:0] target;

    assign iaddr_out            = pc_q;
    assign pc_plus_4_out        = pc_q + XLEN'(4);
    assign fetch_valid_out      = (state_q != ST_RESET);
    assign redirect_pending_out = (state_q == ST_HOLD);
    assign adv                  = fetch_valid_out & ahb_ready_in & ~stall_in;

    always_comb begin
        br_req = (pc_src_in == 2'b11) & branch_taken_in;
`ifdef PCFETCH_RVC_EN
        misaligned = 1'b0;
`else
        misaligned = br_req & iaddr_in[1];
`endif
        // A misaligned branch degrades to the sequential path, so it is not a redirect.
        redirect = (pc_src_in != 2'b11) | (br_req & ~misaligned);

        case (pc_src_in)
            2'b00:   target = RST_PC;
            2'b01:   target = epc_in;
            2'b10:   target = trap_address_in;
            default: target = br_req ? (iaddr_in & ~XLEN'(1)) : pc_plus_4_out;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        hold_addr_d = hold_addr_q;
        hold_br_d   = hold_br_q;
        mis_d       = misaligned;

        case (state_q)
            ST_RESET: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (adv) begin
                    pc_d = redirect ? target : pc_plus_4_out;
                end else if (redirect) begin
                    hold_addr_d = target;
                    hold_br_d   = (pc_src_in == 2'b11);
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (adv) begin
                    pc_d    = redirect ? target : hold_addr_q;
                    state_d = ST_RUN;
                end else if (redirect && (pc_src_in != 2'b11 || hold_br_q)) begin
                    // A branch may only replace a parked branch, never a trap/EPC/reset redirect.
                    hold_addr_d = target;
                    hold_br_d   = (pc_src_in == 2'b11);
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ST_RESET;
            pc_q    <= RST_PC;
            hold_br_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_br_q <= hold_br_d;
            mis_q   <= mis_d;
        end
    end

    always_ff @(posedge clk_in) begin
        hold_addr_q <= hold_addr_d;
    end

`ifdef PCFETCH_RVC_EN
    assign misaligned_instr_logic_out = 1'b0;
`else
    assign misaligned_instr_logic_out = mis_q;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: vector table through a scoreboard, plus hold/reset/wrap sequences.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  src;
    logic        bt;
    logic [31:0] ia, epc, trap;
    logic        stall, ready;
    logic [31:0] addr_o, pc4_o;
    logic        valid_o, pend_o, mis_o;

    logic        rst16;
    logic [1:0]  src16;
    logic        bt16;
    logic [15:0] ia16, epc16, trap16;
    logic        stall16, ready16;
    logic [15:0] addr16_o, pc4_16_o;
    logic        valid16_o, pend16_o, mis16_o;

    pc_fetch_ctrl #(.XLEN(32), .RESET_VECTOR(32'h0000_0000)) dut32 (
        .clk_in(clk), .rst_in(rst), .pc_src_in(src), .branch_taken_in(bt),
        .iaddr_in(ia), .epc_in(epc), .trap_address_in(trap),
        .stall_in(stall), .ahb_ready_in(ready),
        .iaddr_out(addr_o), .pc_plus_4_out(pc4_o), .fetch_valid_out(valid_o),
        .redirect_pending_out(pend_o), .misaligned_instr_logic_out(mis_o)
    );

    pc_fetch_ctrl #(.XLEN(16), .RESET_VECTOR(32'h0000_FFF0)) dut16 (
        .clk_in(clk), .rst_in(rst16), .pc_src_in(src16), .branch_taken_in(bt16),
        .iaddr_in(ia16), .epc_in(epc16), .trap_address_in(trap16),
        .stall_in(stall16), .ahb_ready_in(ready16),
        .iaddr_out(addr16_o), .pc_plus_4_out(pc4_16_o), .fetch_valid_out(valid16_o),
        .redirect_pending_out(pend16_o), .misaligned_instr_logic_out(mis16_o)
    );

    typedef struct {
        logic [1:0]  src;
        logic        bt;
        logic [31:0] ia, epc, trap;
        logic        stall, ready;
        logic [31:0] exp_addr;
        logic        exp_pend, exp_mis;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        valid, pend, mis;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    localparam int NV = 22;
    vec_t vt [NV];

    function automatic vec_t mk(input logic [1:0] s, input logic b, input logic [31:0] i,
                                input logic [31:0] e, input logic [31:0] t, input logic st,
                                input logic rd, input logic [31:0] ea, input logic ep,
                                input logic em);
        vec_t v;
        v.src = s; v.bt = b; v.ia = i; v.epc = e; v.trap = t; v.stall = st; v.ready = rd;
        v.exp_addr = ea; v.exp_pend = ep; v.exp_mis = em;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] s, input logic b, input logic [31:0] i,
                         input logic [31:0] e, input logic [31:0] t, input logic st,
                         input logic rd);
        src = s; bt = b; ia = i; epc = e; trap = t; stall = st; ready = rd;
    endtask

    task automatic push(input string nm, input logic [31:0] a, input logic v,
                        input logic p, input logic m);
        exp_t x;
        x.name = nm; x.addr = a; x.valid = v; x.pend = p; x.mis = m;
        sb.push_back(x);
    endtask

    task automatic pop_cmp();
        exp_t x;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty actual=0 required=1");
            return;
        end
        x = sb.pop_front();
        chk({x.name, "_addr"},  addr_o, x.addr);
        chk({x.name, "_pc4"},   pc4_o, x.addr + 32'd4);
        chk({x.name, "_valid"}, {31'd0, valid_o}, {31'd0, x.valid});
        chk({x.name, "_pend"},  {31'd0, pend_o},  {31'd0, x.pend});
        chk({x.name, "_mis"},   {31'd0, mis_o},   {31'd0, x.mis});
    endtask

    // Drive one cycle, record the expectation, then compare after the edge.
    task automatic cyc(input string nm, input logic [1:0] s, input logic b,
                       input logic [31:0] i, input logic [31:0] e, input logic [31:0] t,
                       input logic rd, input logic [31:0] ea, input logic ep,
                       input logic em);
        drive(s, b, i, e, t, 1'b0, rd);
        push(nm, ea, 1'b1, ep, em);
        tick();
        pop_cmp();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            src    bt  ia          epc         trap        st  rd  exp_addr    pend mis
        vt[0]  = mk(2'b11, 0, 32'h0,     32'h0,     32'h0,     0, 1, 32'h0,     0, 0);
        vt[1]  = mk(2'b11, 0, 32'h0,     32'h0,     32'h0,     0, 1, 32'h4,     0, 0);
        vt[2]  = mk(2'b11, 0, 32'h0,     32'h0,     32'h0,     0, 1, 32'h8,     0, 0);
        vt[3]  = mk(2'b11, 0, 32'h0,     32'h0,     32'h0,     0, 1, 32'hC,     0, 0);
        vt[4]  = mk(2'b01, 0, 32'h0,     32'h100,   32'h0,     0, 1, 32'h100,   0, 0);
        vt[5]  = mk(2'b11, 1, 32'h202,   32'h0,     32'h0,     0, 1, 32'h104,   0, 1);
        vt[6]  = mk(2'b11, 0, 32'h0,     32'h0,     32'h0,     0, 1, 32'h108,   0, 0);
        vt[7]  = mk(2'b01, 0, 32'h0,     32'h100,   32'h0,     0, 1, 32'h100,   0, 0);
        vt[8]  = mk(2'b11, 1, 32'h201,   32'h0,     32'h0,     0, 1, 32'h200,   0, 0);
        vt[9]  = mk(2'b10, 0, 32'h0,     32'h0,     32'h80,    0, 1, 32'h80,    0, 0);
        vt[10] = mk(2'b11, 0, 32'h0,     32'h0,     32'h0,     1, 1, 32'h80,    0, 0);
        vt[11] = mk(2'b11, 1, 32'h400,   32'h0,     32'h0,     1, 1, 32'h80,    1, 0);
        vt[12] = mk(2'b11, 0, 32'h0,     32'h0,     32'h0,     0, 1, 32'h400,   0, 0);
        vt[13] = mk(2'b11, 0, 32'h0,     32'h0,     32'h0,     0, 1, 32'h404,   0, 0);
        vt[14] = mk(2'b11, 1, 32'h500,   32'h0,     32'h0,     0, 0, 32'h404,   1, 0);
        vt[15] = mk(2'b10, 0, 32'h0,     32'h0,     32'hC0,    0, 0, 32'h404,   1, 0);
        vt[16] = mk(2'b11, 1, 32'h600,   32'h0,     32'h0,     0, 0, 32'h404,   1, 0);
        vt[17] = mk(2'b11, 0, 32'h0,     32'h0,     32'h0,     0, 1, 32'hC0,    0, 0);
        vt[18] = mk(2'b01, 0, 32'h0,     32'h700,   32'h0,     0, 0, 32'hC0,    1, 0);
        vt[19] = mk(2'b10, 0, 32'h0,     32'h0,     32'h900,   0, 1, 32'h900,   0, 0);
        vt[20] = mk(2'b11, 1, 32'h302,   32'h0,     32'h0,     0, 0, 32'h900,   0, 1);
        vt[21] = mk(2'b11, 0, 32'h0,     32'h0,     32'h0,     0, 1, 32'h904,   0, 0);

        rst = 1'b1;
        drive(2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        rst16 = 1'b1;
        src16 = 2'b11; bt16 = 1'b0; ia16 = 16'h0; epc16 = 16'h0; trap16 = 16'h0;
        stall16 = 1'b0; ready16 = 1'b1;
        tick();
        tick();
        chk("rst_addr",  addr_o, 32'h0);
        chk("rst_pc4",   pc4_o, 32'h4);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_pend",  {31'd0, pend_o},  32'd0);
        chk("rst_mis",   {31'd0, mis_o},   32'd0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vt[i].src, vt[i].bt, vt[i].ia, vt[i].epc, vt[i].trap, vt[i].stall, vt[i].ready);
            push($sformatf("row%0d", i), vt[i].exp_addr, 1'b1, vt[i].exp_pend, vt[i].exp_mis);
            tick();
            pop_cmp();
        end

        // Trap parked under wait states; a later branch must not displace it.
        cyc("wait_trap",   2'b10, 1'b0, 32'h0,   32'h0, 32'h80, 1'b0, 32'h904, 1'b1, 1'b0);
        cyc("wait_branch", 2'b11, 1'b1, 32'h300, 32'h0, 32'h0,  1'b0, 32'h904, 1'b1, 1'b0);
        cyc("wait_idle",   2'b11, 1'b0, 32'h0,   32'h0, 32'h0,  1'b0, 32'h904, 1'b1, 1'b0);
        cyc("wait_done",   2'b11, 1'b0, 32'h0,   32'h0, 32'h0,  1'b1, 32'h80,  1'b0, 1'b0);

        // EPC parked, then asynchronous reset in the middle of the cycle.
        cyc("epc_park",    2'b01, 1'b0, 32'h0,   32'h40, 32'h0, 1'b0, 32'h80,  1'b1, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_addr",  addr_o, 32'h0);
        chk("arst_pend",  {31'd0, pend_o},  32'd0);
        chk("arst_valid", {31'd0, valid_o}, 32'd0);
        chk("arst_pc4",   pc4_o, 32'h4);
        tick();
        rst = 1'b0;
        cyc("arst_run",   2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
        cyc("arst_seq",   2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h4, 1'b0, 1'b0);

        // 16-bit instance: reset vector truncation and sequential wrap to zero.
        chk("x16_rst_addr", {16'd0, addr16_o}, 32'hFFF0);
        rst16 = 1'b0;
        tick();
        chk("x16_run_addr",  {16'd0, addr16_o}, 32'hFFF0);
        chk("x16_run_valid", {31'd0, valid16_o}, 32'd1);
        tick();
        tick();
        tick();
        chk("x16_top_addr", {16'd0, addr16_o}, 32'hFFFC);
        chk("x16_top_pc4",  {16'd0, pc4_16_o}, 32'h0000);
        tick();
        chk("x16_wrap_addr", {16'd0, addr16_o}, 32'h0000);
        chk("x16_wrap_pc4",  {16'd0, pc4_16_o}, 32'h0004);
        chk("x16_wrap_mis",  {31'd0, mis16_o}, 32'd0);
        chk("x16_wrap_pend", {31'd0, pend16_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
